// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates icache and dcache requests onto a single byte-wide
// RAM/IO port. One 1/2/4-byte access at a time is serialised into byte
// cycles. Assembled load data is returned with a one-cycle done pulse.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rdy                global enable; low freezes all state (mem_wr forced 0)
//   o_wait[1:0]        registered hold for icache (bit0) / dcache (bit1)
//   i_ic_*             icache fetch request (always 4 bytes), abort, done/data
//   i_dc_*             dcache load/store request, done/load data
//   mem_din/mem_dout   RAM read byte (one cycle after address) / write byte
//   mem_a, mem_wr      RAM byte address and write strobe
//   io_buffer_full     stalls writes to addresses >= IO_BASE
module mem_ctrl #(
  parameter int                 ADDR_W  = 32,
  parameter logic [ADDR_W-1:0]  IO_BASE = 32'h00030000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic [1:0]        o_wait,
  input  logic              i_ic_en,
  input  logic [ADDR_W-1:0] i_ic_pc,
  input  logic              i_ic_clr,
  output logic              o_ic_done,
  output logic [31:0]       o_ic_dt,
  input  logic              i_dc_en,
  input  logic              i_dc_ls,
  input  logic [ADDR_W-1:0] i_dc_pc,
  input  logic [31:0]       i_dc_dt,
  input  logic [2:0]        i_dc_len,
  output logic              o_dc_done,
  output logic [31:0]       o_dc_dt,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [1:0]        wait_q;

  logic [ADDR_W-1:0] base_q;
  logic [2:0]        len_q;
  logic              ls_q;
  logic              own_dc_q;
  logic [31:0]       sdata_q;
  logic [31:0]       dt_q;

  logic              grant_dc;
  logic              grant_ic;
  logic [ADDR_W-1:0] cur_a;
  logic              stall;
  logic              rd_active;
  logic              wr_active;
  logic [1:0]        k_prev;

  // Byte lane k of a little-endian word.
  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] k);
    byte_lane = w[{k, 3'b000} +: 8];
  endfunction

  assign cur_a     = base_q + ADDR_W'(k_q);
  assign rd_active = (state_q == RD) && (k_q < len_q);
  assign wr_active = (state_q == WR);
  // Only writes into IO space are held back by the IO buffer.
  assign stall     = wr_active && (cur_a >= IO_BASE) && io_buffer_full;
  assign k_prev    = k_q[1:0] - 2'd1;

  // Next-state: arbitration, byte sequencing and abort
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    grant_dc = 1'b0;
    grant_ic = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_dc_en) begin
          grant_dc = 1'b1;
          state_d  = i_dc_ls ? WR : RD;
          k_d      = 3'd0;
        end else if (i_ic_en) begin
          grant_ic = 1'b1;
          state_d  = RD;
          k_d      = 3'd0;
        end
      end
      RD: begin
        // k runs one past the last address so the final byte can be sampled.
        if (!own_dc_q && i_ic_clr) begin
          state_d = IDLE;
          k_d     = 3'd0;
        end else if (k_q == len_q) begin
          state_d = DONE;
          k_d     = 3'd0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      WR: begin
        if (!stall) begin
          if (k_q == len_q - 3'd1) begin
            state_d = DONE;
            k_d     = 3'd0;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        k_d     = 3'd0;
      end
      default: begin
        state_d = IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      wait_q  <= 2'b00;
    end else if (rdy) begin
      state_q <= state_d;
      k_q     <= k_d;
      wait_q  <= (state_d != IDLE) ? 2'b11 : 2'b00;
    end
  end

  // Request fields latched at grant; read bytes assembled one cycle after address
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (grant_dc) begin
        base_q   <= i_dc_pc;
        len_q    <= i_dc_len;
        ls_q     <= i_dc_ls;
        own_dc_q <= 1'b1;
        sdata_q  <= i_dc_dt;
        dt_q     <= 32'd0;
      end else if (grant_ic) begin
        base_q   <= i_ic_pc;
        len_q    <= 3'd4;
        ls_q     <= 1'b0;
        own_dc_q <= 1'b0;
        sdata_q  <= 32'd0;
        dt_q     <= 32'd0;
      end else if (state_q == RD && k_q != 3'd0) begin
        dt_q[{k_prev, 3'b000} +: 8] <= mem_din;
      end
    end
  end

  // Output decode
  always_comb begin
    o_wait    = wait_q;
    mem_a     = '0;
    mem_wr    = 1'b0;
    mem_dout  = 8'd0;
    o_ic_done = 1'b0;
    o_ic_dt   = 32'd0;
    o_dc_done = 1'b0;
    o_dc_dt   = 32'd0;
    if (rd_active || wr_active)
      mem_a = cur_a;
    if (wr_active) begin
      mem_dout = byte_lane(sdata_q, k_q[1:0]);
      mem_wr   = rdy && !stall;
    end
    if (state_q == DONE && rdy) begin
      if (own_dc_q) begin
        o_dc_done = 1'b1;
        o_dc_dt   = ls_q ? 32'd0 : dt_q;
      end else if (!i_ic_clr) begin
        o_ic_done = 1'b1;
        o_ic_dt   = dt_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [1:0]  o_wait;
  logic        i_ic_en, i_ic_clr, o_ic_done;
  logic [31:0] i_ic_pc, o_ic_dt;
  logic        i_dc_en, i_dc_ls, o_dc_done;
  logic [31:0] i_dc_pc, i_dc_dt, o_dc_dt;
  logic [2:0]  i_dc_len;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .o_wait(o_wait),
    .i_ic_en(i_ic_en), .i_ic_pc(i_ic_pc), .i_ic_clr(i_ic_clr),
    .o_ic_done(o_ic_done), .o_ic_dt(o_ic_dt),
    .i_dc_en(i_dc_en), .i_dc_ls(i_dc_ls), .i_dc_pc(i_dc_pc), .i_dc_dt(i_dc_dt),
    .i_dc_len(i_dc_len), .o_dc_done(o_dc_done), .o_dc_dt(o_dc_dt),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, data one cycle after address
  logic [7:0] ram [int unsigned];
  always @(posedge clk) mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;

  typedef struct { logic is_dc; logic [31:0] data; int c; } done_t;
  typedef struct { int c; logic [31:0] a; logic [7:0] d; } wr_t;
  done_t dq[$];
  wr_t   wq[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_done(input logic is_dc, input logic [31:0] d, input int c);
    done_t e;
    e.is_dc = is_dc; e.data = d; e.c = c;
    dq.push_back(e);
  endtask

  task automatic push_wr(input int c, input logic [31:0] a, input logic [7:0] d);
    wr_t e;
    e.c = c; e.a = a; e.d = d;
    wq.push_back(e);
  endtask

  // Monitor: compares every done pulse and every write strobe against the scoreboards
  always @(negedge clk) begin
    if (o_ic_done || o_dc_done) begin
      if (dq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: ic=%b dc=%b, none expected (cycle %0d)", o_ic_done, o_dc_done, cyc);
      end else begin
        done_t e;
        e = dq.pop_front();
        chk("done_owner", {31'd0, o_dc_done}, {31'd0, e.is_dc});
        chk("done_data", o_dc_done ? o_dc_dt : o_ic_dt, e.data);
        chk("done_cycle", 32'(cyc), 32'(e.c));
      end
    end
    if (mem_wr) begin
      if (wq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: a=%h d=%h, none expected (cycle %0d)", mem_a, mem_dout, cyc);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", mem_a, w.a);
        chk("wr_data", {24'd0, mem_dout}, {24'd0, w.d});
        chk("wr_cycle", 32'(cyc), 32'(w.c));
      end
    end
  end

  int g;

  initial begin
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
    i_ic_en = 1'b0; i_ic_pc = 32'd0; i_ic_clr = 1'b0;
    i_dc_en = 1'b0; i_dc_ls = 1'b0; i_dc_pc = 32'd0; i_dc_dt = 32'd0; i_dc_len = 3'd0;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h2002] = 8'hAB; ram[32'h2003] = 8'hCD;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    chk("rst_wait", {30'd0, o_wait}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_dones", {30'd0, o_ic_done, o_dc_done}, 32'd0);
    chk("rst_dts", o_ic_dt | o_dc_dt, 32'd0);
    tick();
    rst = 1'b0;

    // Icache fetch of 0x1000
    tick();
    i_ic_en = 1'b1; i_ic_pc = 32'h1000;
    tick(); g = cyc;
    i_ic_en = 1'b0; i_ic_pc = 32'hFFFF_FFF0;
    push_done(1'b0, 32'h0000_0513, g + 5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fetch_addr", mem_a, 32'h1000 + 32'(k));
      chk("fetch_wait", {30'd0, o_wait}, 32'd3);
    end
    @(negedge clk); chk("fetch_wait", {30'd0, o_wait}, 32'd3);
    @(negedge clk); chk("fetch_wait_done", {30'd0, o_wait}, 32'd3);
    @(negedge clk); chk("fetch_wait_idle", {30'd0, o_wait}, 32'd0);
    tick();

    // Simultaneous requests: dcache load first, icache after
    tick();
    i_ic_en = 1'b1; i_ic_pc = 32'h1000;
    i_dc_en = 1'b1; i_dc_ls = 1'b0; i_dc_pc = 32'h2002; i_dc_len = 3'd2;
    tick(); g = cyc;
    i_dc_en = 1'b0; i_dc_pc = 32'd0;
    push_done(1'b1, 32'h0000_CDAB, g + 3);
    push_done(1'b0, 32'h0000_0513, g + 10);
    repeat (5) tick();
    i_ic_en = 1'b0;
    repeat (7) tick();

    // Dcache store of 0xDEADBEEF to 0x100
    i_dc_en = 1'b1; i_dc_ls = 1'b1; i_dc_pc = 32'h100; i_dc_dt = 32'hDEAD_BEEF; i_dc_len = 3'd4;
    tick(); g = cyc;
    i_dc_en = 1'b0; i_dc_dt = 32'd0;
    push_wr(g,     32'h100, 8'hEF);
    push_wr(g + 1, 32'h101, 8'hBE);
    push_wr(g + 2, 32'h102, 8'hAD);
    push_wr(g + 3, 32'h103, 8'hDE);
    push_done(1'b1, 32'd0, g + 4);
    repeat (7) tick();

    // IO store stalled by io_buffer_full for 3 cycles
    io_buffer_full = 1'b1;
    i_dc_en = 1'b1; i_dc_ls = 1'b1; i_dc_pc = 32'h0003_0000; i_dc_dt = 32'h41; i_dc_len = 3'd1;
    tick(); g = cyc;
    i_dc_en = 1'b0;
    push_wr(g + 3, 32'h0003_0000, 8'h41);
    push_done(1'b1, 32'd0, g + 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("io_stall_wr", {31'd0, mem_wr}, 32'd0);
      tick();
    end
    io_buffer_full = 1'b0;
    repeat (5) tick();

    // Icache abort during 2nd byte, pending dcache load granted right after
    i_ic_en = 1'b1; i_ic_pc = 32'h1000;
    tick(); g = cyc;
    i_ic_en = 1'b0;
    tick();
    i_ic_clr = 1'b1;
    i_dc_en = 1'b1; i_dc_ls = 1'b0; i_dc_pc = 32'h2002; i_dc_len = 3'd1;
    tick();
    i_ic_clr = 1'b0;
    @(negedge clk);
    chk("clr_wait_idle", {30'd0, o_wait}, 32'd0);
    chk("clr_mem_a", mem_a, 32'd0);
    tick();
    i_dc_en = 1'b0;
    push_done(1'b1, 32'h0000_00AB, g + 5);
    @(negedge clk);
    chk("clr_dc_granted", {30'd0, o_wait}, 32'd3);
    repeat (5) tick();

    // rdy low for one cycle during a 2-byte store
    i_dc_en = 1'b1; i_dc_ls = 1'b1; i_dc_pc = 32'h300; i_dc_dt = 32'h5566; i_dc_len = 3'd2;
    tick(); g = cyc;
    i_dc_en = 1'b0;
    push_wr(g,     32'h300, 8'h66);
    push_wr(g + 2, 32'h301, 8'h55);
    push_done(1'b1, 32'd0, g + 3);
    tick();
    rdy = 1'b0;
    @(negedge clk);
    chk("frozen_wr", {31'd0, mem_wr}, 32'd0);
    tick();
    rdy = 1'b1;
    repeat (5) tick();

    // Reset in the middle of a store after 2 bytes
    i_dc_en = 1'b1; i_dc_ls = 1'b1; i_dc_pc = 32'h200; i_dc_dt = 32'h1122_3344; i_dc_len = 3'd4;
    tick(); g = cyc;
    i_dc_en = 1'b0;
    push_wr(g,     32'h200, 8'h44);
    push_wr(g + 1, 32'h201, 8'h33);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_wr", {31'd0, mem_wr}, 32'd0);
    chk("midrst_a", mem_a, 32'd0);
    chk("midrst_wait", {30'd0, o_wait}, 32'd0);
    chk("midrst_dout", {24'd0, mem_dout}, 32'd0);
    chk("midrst_done", {31'd0, o_dc_done}, 32'd0);
    repeat (8) tick();

    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    chk("write_queue_empty", 32'(wq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
